fp16_pair_packer: RTL and testbench

//  Streaming stage downstream of the fp32->fp16 converter. Accepts one fp16 value per cycle
//  on a valid/ready stream and packs consecutive pairs into 32-bit words for the memory/bus

---
 rtl/fp16_pair_packer_pkg.sv | 20 ++
 rtl/fp16_pair_packer_classify.sv | 33 +++
 rtl/fp16_pair_packer.sv | 103 ++++++++++
 tb/tb_fp16_pair_packer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pair_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp16_pair_packer_pkg
// Description : Shared fp16 field constants and packer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fp16_pair_packer_pkg;

  // fp16 field layout shared with the converter and its benches
  localparam int          FP16_EXP_W   = 5;
  localparam int          FP16_MANT_W  = 10;
  localparam logic [4:0]  FP16_EXP_MAX = 5'h1F;
  localparam logic [15:0] FP16_QNAN    = 16'h7E00;

  // Packer state: whether a first half is being held
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HALF  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/fp16_pair_packer_classify.sv
`default_nettype none
// ============================================================================
// Module      : fp_classify
// Description : Flags an fp16 value as NaN or infinity (either sign).
// Revision    : 1.0 - initial release
// ============================================================================
module fp_classify
  import fp16_pair_packer_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] data,
  output logic         is_nan,
  output logic         is_inf
);

  localparam logic [W-1:0] c_sign_mask = {1'b1, {(W-1){1'b0}}};

  logic [W-1:0]             w_abs;
  logic [FP16_EXP_W-1:0]    w_exp;
  logic [FP16_MANT_W-1:0]   w_mant;

  // Sign is irrelevant to the class; strip it before slicing the fields
  always_comb begin
    w_abs  = data & ~c_sign_mask;
    w_exp  = w_abs[FP16_MANT_W +: FP16_EXP_W];
    w_mant = w_abs[FP16_MANT_W-1:0];
    is_nan = (w_exp == FP16_EXP_MAX) && (w_mant != '0);
    is_inf = (w_exp == FP16_EXP_MAX) && (w_mant == '0);
  end

endmodule
`default_nettype wire

// File: rtl/fp16_pair_packer.sv
`default_nettype none
// ============================================================================
// Module      : fp16_pair_packer
// Description : Packs pairs of fp16 stream elements into 32-bit words, pads
//               odd packet tails, and keeps saturating NaN/Inf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fp16_pair_packer
  import fp16_pair_packer_pkg::*;
#(
  parameter logic [15:0] PAD_VALUE = 16'h0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [31:0]      o_data,
  output logic [1:0]       o_mask,
  output logic             o_last,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] nan_cnt,
  output logic [CNT_W-1:0] inf_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  logic [0:0]  r_state;
  logic [15:0] r_lo;
  logic        w_accept;
  logic        w_load;
  logic        w_is_nan;
  logic        w_is_inf;

  fp_classify #(.W(16)) u_classify (
    .data   (in_data),
    .is_nan (w_is_nan),
    .is_inf (w_is_inf)
  );

  // Accept whenever the output slot is free or is being drained this cycle
  always_comb begin
    in_ready = rst_n & (~o_valid | o_ready);
    w_accept = in_valid & in_ready;
    w_load   = w_accept & ((r_state == ST_HALF) | in_last);
  end

  // Pairing state, held low half and the output word register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_lo    <= 16'h0000;
      o_valid <= 1'b0;
      o_data  <= 32'h0000_0000;
      o_mask  <= 2'b00;
      o_last  <= 1'b0;
    end else begin
      if (w_accept) begin
        if (r_state == ST_HALF) begin
          r_state <= ST_EMPTY;
          o_data  <= {in_data, r_lo};
          o_mask  <= 2'b11;
          o_last  <= in_last;
        end else if (in_last) begin
          o_data  <= {PAD_VALUE, in_data};
          o_mask  <= 2'b01;
          o_last  <= 1'b1;
        end else begin
          r_state <= ST_HALF;
          r_lo    <= in_data;
        end
      end
      // A new word takes precedence over the drain of the previous one
      if (w_load) begin
        o_valid <= 1'b1;
      end else if (o_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

  // Saturating statistics; a clear wins over a same-cycle count
  always_ff @(posedge clk) begin
    if (!rst_n || clr_stats) begin
      nan_cnt <= '0;
      inf_cnt <= '0;
    end else if (w_accept) begin
      if (w_is_nan && (nan_cnt != c_cnt_max)) begin
        nan_cnt <= nan_cnt + c_cnt_one;
      end
      if (w_is_inf && (inf_cnt != c_cnt_max)) begin
        inf_cnt <= inf_cnt + c_cnt_one;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp16_pair_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp16_pair_packer
// Description : Directed self-checking bench for fp16_pair_packer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp16_pair_packer;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, in_last;
  logic [15:0] in_data;
  logic        o_valid, o_ready, o_last;
  logic [31:0] o_data;
  logic [1:0]  o_mask;
  logic        clr_stats;
  logic [15:0] nan_cnt, inf_cnt;

  // Narrow-counter instance for saturation
  logic        s_in_valid, s_in_ready, s_in_last;
  logic [15:0] s_in_data;
  logic        s_o_valid, s_o_ready, s_o_last;
  logic [31:0] s_o_data;
  logic [1:0]  s_o_mask;
  logic        s_clr_stats;
  logic [3:0]  s_nan_cnt, s_inf_cnt;

  int total = 0;
  int bad   = 0;

  // Random-run scoreboard state
  logic        rnd_on = 1'b0;
  int          acc_cnt = 0;
  logic        m_half = 1'b0;
  logic [15:0] m_lo = 16'h0000;
  logic [34:0] exp_q[$];

  fp16_pair_packer #(.PAD_VALUE(16'h0000), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .o_valid(o_valid), .o_ready(o_ready),
    .o_data(o_data), .o_mask(o_mask), .o_last(o_last), .clr_stats(clr_stats),
    .nan_cnt(nan_cnt), .inf_cnt(inf_cnt)
  );

  fp16_pair_packer #(.PAD_VALUE(16'h0000), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .in_last(s_in_last), .o_valid(s_o_valid), .o_ready(s_o_ready),
    .o_data(s_o_data), .o_mask(s_o_mask), .o_last(s_o_last), .clr_stats(s_clr_stats),
    .nan_cnt(s_nan_cnt), .inf_cnt(s_inf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model for the random run: pre-edge view of both handshakes
  always @(posedge clk) begin
    if (rnd_on) begin
      if (o_valid && o_ready) begin
        if (exp_q.size() == 0) begin
          check("rnd_extra_word", {o_last, o_mask, o_data}, 35'h0);
        end else begin
          check("rnd_word", {o_last, o_mask, o_data}, exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        acc_cnt++;
        if (!m_half) begin
          if (in_last) exp_q.push_back({1'b1, 2'b01, 16'h0000, in_data});
          else begin
            m_half = 1'b1;
            m_lo   = in_data;
          end
        end else begin
          exp_q.push_back({in_last, 2'b11, in_data, m_lo});
          m_half = 1'b0;
        end
      end
    end
  end

  // Hard stop in case something never completes
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 16'h0; in_last = 1'b0;
    o_ready = 1'b1; clr_stats = 1'b0;
    s_in_valid = 1'b0; s_in_data = 16'h0; s_in_last = 1'b0;
    s_o_ready = 1'b1; s_clr_stats = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_o_valid", o_valid, 0);
    check("rst_o_data", o_data, 0);
    check("rst_o_mask", o_mask, 0);
    check("rst_o_last", o_last, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_nan", nan_cnt, 0);
    check("rst_inf", inf_cnt, 0);
    rst_n = 1'b1;
    tick();
    check("in_ready_idle", in_ready, 1);

    // Simple pair
    in_valid = 1'b1; in_data = 16'h3C00; in_last = 1'b0;
    tick();
    check("pair_no_out_after_first", o_valid, 0);
    in_data = 16'h4000; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    check("pair_word", {o_last, o_mask, o_data}, {1'b1, 2'b11, 32'h4000_3C00});
    check("pair_valid", o_valid, 1);
    tick();
    check("pair_drained", o_valid, 0);

    // Odd tail
    in_valid = 1'b1; in_data = 16'h3C00; in_last = 1'b0;
    tick();
    in_data = 16'h4000;
    tick();
    check("odd_word1", {o_valid, o_last, o_mask, o_data}, {1'b1, 1'b0, 2'b11, 32'h4000_3C00});
    in_data = 16'h4200; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    check("odd_word2", {o_valid, o_last, o_mask, o_data}, {1'b1, 1'b1, 2'b01, 32'h0000_4200});
    tick();
    check("odd_drained", o_valid, 0);

    // Backpressure
    o_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h3C00; in_last = 1'b0;
    tick();
    in_data = 16'h1111; in_last = 1'b1;
    tick();
    in_data = 16'h2222; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", in_ready, 0);
      check("bp_hold", {o_valid, o_last, o_mask, o_data}, {1'b1, 1'b1, 2'b11, 32'h1111_3C00});
      tick();
    end
    o_ready = 1'b1;
    #1;
    check("bp_in_ready_release", in_ready, 1);
    tick();
    check("bp_no_dup", o_valid, 0);
    in_data = 16'h3333; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    check("bp_next_word", {o_valid, o_last, o_mask, o_data}, {1'b1, 1'b1, 2'b11, 32'h3333_2222});
    tick();

    // Random stream against the scoreboard
    rnd_on = 1'b1;
    cyc = 0;
    while (acc_cnt < 1000 && cyc < 20000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 16'($urandom);
      in_last  = ($urandom_range(0, 3) == 0);
      o_ready  = ($urandom_range(0, 2) != 0);
      tick();
      cyc++;
    end
    o_ready = 1'b1; in_valid = 1'b1; in_last = 1'b1; in_data = 16'h5555;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    tick(); tick(); tick();
    rnd_on = 1'b0;
    check("rnd_enough_elems", (acc_cnt >= 1000), 1);
    check("rnd_queue_empty", exp_q.size(), 0);

    // Statistics
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("stats_cleared", {nan_cnt, inf_cnt}, 0);
    in_valid = 1'b1; in_last = 1'b0;
    in_data = 16'h7C00; tick();
    in_data = 16'hFC00; tick();
    in_data = 16'h7E01; tick();
    in_data = 16'h7C01; tick();
    in_data = 16'h3C00; in_last = 1'b1; tick();
    in_valid = 1'b0; in_last = 1'b0;
    check("stats_tail_word", {o_valid, o_last, o_mask, o_data}, {1'b1, 1'b1, 2'b01, 32'h0000_3C00});
    check("stats_inf", inf_cnt, 2);
    check("stats_nan", nan_cnt, 2);
    tick();
    clr_stats = 1'b1; in_valid = 1'b1; in_data = 16'h7C00; in_last = 1'b1;
    tick();
    clr_stats = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    check("clr_priority_inf", inf_cnt, 0);
    check("clr_priority_nan", nan_cnt, 0);
    check("clr_elem_still_packed", {o_valid, o_mask, o_data}, {1'b1, 2'b01, 32'h0000_7C00});
    tick();

    // Reset mid-packet
    in_valid = 1'b1; in_data = 16'h3C00; in_last = 1'b0;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 0);
    tick();
    check("midrst_outputs", {o_valid, o_last, o_mask, o_data}, 0);
    check("midrst_counters", {nan_cnt, inf_cnt}, 0);
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 16'h4000; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    check("midrst_word", {o_valid, o_last, o_mask, o_data}, {1'b1, 1'b1, 2'b01, 32'h0000_4000});
    tick();

    // Counter saturation on the narrow instance
    check("sat_start", s_nan_cnt, 0);
    s_in_valid = 1'b1; s_in_data = 16'h7E00; s_in_last = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 14) check("sat_reach_f", s_nan_cnt, 4'hF);
    end
    s_in_valid = 1'b0;
    check("sat_stays_f", s_nan_cnt, 4'hF);
    check("sat_inf_zero", s_inf_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
